// File: rtl/hilo_muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Optional feature: define MULDIV_CANCEL_EN to add a cancel input that aborts a running operation.
module hilo_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
`ifdef MULDIV_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        mult,
  input  logic        multu,
  input  logic        div,
  input  logic        divu,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic        stall
);

  localparam int unsigned W     = 32;
  localparam int unsigned CW    = 5;
  localparam int unsigned LASTI = 31;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_is_div;
  logic           r_sa;
  logic           r_sb;
  logic           r_zdiv;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_hw;
  logic [W-1:0]   r_lw;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_done;
  logic           r_dbz;

  logic           w_start;
  logic           w_div;
  logic           w_sign;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W:0]     w_mul_sum;
  logic [W:0]     w_trial;
  logic [W-1:0]   w_next_hw;
  logic [W-1:0]   w_next_lw;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_res_hi;
  logic [W-1:0]   w_res_lo;

  // Start decode: div > divu > mult > multu
  assign w_start = div | divu | mult | multu;
  assign w_div   = div | divu;
  assign w_sign  = div | (~divu & mult);
  assign w_abs_a = (w_sign && a[W-1]) ? W'(-a) : a;
  assign w_abs_b = (w_sign && b[W-1]) ? W'(-b) : b;

  // One radix-2 step: shift-add multiply (hw:lw shifts right) or restoring divide (hw:lw shifts left)
  assign w_mul_sum = (W+1)'({1'b0, r_hw}) + (W+1)'({1'b0, (r_lw[0] ? r_opa : {W{1'b0}})});
  assign w_trial   = (W+1)'({r_hw, r_lw[W-1]}) - (W+1)'({1'b0, r_opb});

  always_comb begin
    w_next_hw = w_mul_sum[W:1];
    w_next_lw = {w_mul_sum[0], r_lw[W-1:1]};
    if (r_is_div) begin
      w_next_hw = w_trial[W] ? {r_hw[W-2:0], r_lw[W-1]} : w_trial[W-1:0];
      w_next_lw = {r_lw[W-2:0], ~w_trial[W]};
    end
  end

  // Sign correction of the magnitude result; divide-by-zero returns the raw dividend
  always_comb begin
    w_prod   = {r_hw, r_lw};
    if (r_sa ^ r_sb) w_prod = (2*W)'(-w_prod);
    w_res_hi = w_prod[2*W-1:W];
    w_res_lo = w_prod[W-1:0];
    if (r_is_div) begin
      if (r_zdiv) begin
        w_res_hi = r_sa ? W'(-r_opa) : r_opa;
        w_res_lo = {W{1'b1}};
      end else begin
        w_res_hi = r_sa ? W'(-r_hw) : r_hw;
        w_res_lo = (r_sa ^ r_sb) ? W'(-r_lw) : r_lw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_zdiv   <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hw     <= '0;
      r_lw     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_is_div <= w_div;
            r_sa     <= w_sign & a[W-1];
            r_sb     <= w_sign & b[W-1];
            r_zdiv   <= w_div & (b == '0);
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_hw     <= '0;
            r_lw     <= w_div ? w_abs_a : w_abs_b;
          end else begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        RUN: begin
          r_hw  <= w_next_hw;
          r_lw  <= w_next_lw;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(LASTI)) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_dbz   <= r_zdiv;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
`ifdef MULDIV_CANCEL_EN
      // Abort overrides everything above, including a FIX-cycle write-back
      if (cancel && r_state != IDLE) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hi    <= r_hi;
        r_lo    <= r_lo;
        r_done  <= 1'b0;
        r_dbz   <= 1'b0;
      end
`endif
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign dbz   = r_dbz;
  assign stall = busy & (rd_hilo | w_start | mthi | mtlo);

endmodule
